// File: rtl/unidad_control_multiciclo.sv
// unidad_control_multiciclo: multicycle MIPS control FSM.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB over a shared memory/ALU datapath,
// one step per clock, and drives every datapath strobe and mux select.
// Optional build macro MC_MEM_HANDSHAKE_EN: FETCH, MEM_RD and MEM_WR wait for
// mem_ready; when undefined, mem_ready is ignored and those states last one cycle.
module unidad_control_multiciclo #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PcWrite,
    output logic             Branch,
    output logic             PcEn,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemToWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic [2:0]       AluOp,
    output logic [1:0]       PcSource,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADR  = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMM_EXEC = 4'd9,
        S_IMM_WB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q;
    logic             mem_ok;

    // Memory-access completion qualifier for the states that touch memory.
`ifdef MC_MEM_HANDSHAKE_EN
    assign mem_ok = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_ok           = 1'b1;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Opcode latch, sticky illegal flag and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            op_q      <= op_d;
            illegal_q <= illegal_d;
            if (instr_done) count_q <= count_q + CNT_W'(1);
        end
    end

    // Next-state logic; DECODE also captures the opcode and flags unsupported ones.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH:    if (mem_ok) state_d = S_DECODE;
            S_DECODE: begin
                op_d = op;
                case (op)
                    OP_RTYPE:                          state_d = S_R_EXEC;
                    OP_LW, OP_SW:                      state_d = S_MEM_ADR;
                    OP_BEQ:                            state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMM_EXEC;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEM_ADR:  state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ok) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ok) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_IMM_EXEC: state_d = S_IMM_WB;
            default:    state_d = S_FETCH;  // MEM_WB, R_WB, BRANCH, IMM_WB, JUMP and codes 12-15
        endcase
    end

    // Moore output decode; strobes are held low for as long as reset is high.
    always_comb begin
        PcWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemToWrite = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemToReg   = 1'b0;
        RegWrite   = 1'b0;
        AluSrcA    = 1'b0;
        AluSrcB    = 2'b00;
        AluOp      = 3'b000;
        PcSource   = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                AluSrcB = 2'b01;
                IRWrite = mem_ok;
                PcWrite = mem_ok;
            end
            S_DECODE:  AluSrcB = 2'b11;
            S_MEM_ADR: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                MemToWrite = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ok;
            end
            S_R_EXEC: begin
                AluSrcA = 1'b1;
                AluOp   = 3'b001;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                AluSrcA    = 1'b1;
                AluOp      = 3'b010;
                PcSource   = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_IMM_EXEC: begin
                AluSrcA = 1'b1;
                AluSrcB = 2'b10;
                case (op_q)
                    OP_ANDI: AluOp = 3'b011;
                    OP_ORI:  AluOp = 3'b100;
                    OP_SLTI: AluOp = 3'b101;
                    default: AluOp = 3'b000;
                endcase
            end
            S_IMM_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PcSource   = 2'b10;
                PcWrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            PcWrite    = 1'b0;
            Branch     = 1'b0;
            MemRead    = 1'b0;
            MemToWrite = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
        end
        PcEn = PcWrite | (Branch & zero);
    end

    assign state       = state_q;
    assign instr_count = count_q;
    assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Scoreboard bench for unidad_control_multiciclo: stimulus pushes hand-written
// per-cycle expectations, a negedge monitor pops and compares them. A second
// instance with CNT_W=2 shares the inputs to observe counter wrap-around.
module tb_unidad_control_multiciclo;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic        zero;
    logic        mem_ready;

    logic        PcWrite, Branch, PcEn, IorD, MemRead, MemToWrite, IRWrite;
    logic        RegDst, MemToReg, RegWrite, AluSrcA, instr_done, illegal_op;
    logic [1:0]  AluSrcB, PcSource;
    logic [2:0]  AluOp;
    logic [3:0]  state;
    logic [31:0] instr_count;

    logic        d2_PcWrite, d2_Branch, d2_PcEn, d2_IorD, d2_MemRead, d2_MemToWrite, d2_IRWrite;
    logic        d2_RegDst, d2_MemToReg, d2_RegWrite, d2_AluSrcA, d2_instr_done, d2_illegal_op;
    logic [1:0]  d2_AluSrcB, d2_PcSource;
    logic [2:0]  d2_AluOp;
    logic [3:0]  d2_state;
    logic [1:0]  d2_count;

    always #5 clk = ~clk;

    unidad_control_multiciclo #(.CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PcWrite(PcWrite), .Branch(Branch), .PcEn(PcEn), .IorD(IorD), .MemRead(MemRead),
        .MemToWrite(MemToWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluOp(AluOp),
        .PcSource(PcSource), .state(state), .instr_done(instr_done),
        .instr_count(instr_count), .illegal_op(illegal_op)
    );

    unidad_control_multiciclo #(.CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .PcWrite(d2_PcWrite), .Branch(d2_Branch), .PcEn(d2_PcEn), .IorD(d2_IorD),
        .MemRead(d2_MemRead), .MemToWrite(d2_MemToWrite), .IRWrite(d2_IRWrite),
        .RegDst(d2_RegDst), .MemToReg(d2_MemToReg), .RegWrite(d2_RegWrite),
        .AluSrcA(d2_AluSrcA), .AluSrcB(d2_AluSrcB), .AluOp(d2_AluOp),
        .PcSource(d2_PcSource), .state(d2_state), .instr_done(d2_instr_done),
        .instr_count(d2_count), .illegal_op(d2_illegal_op)
    );

    // Control word field order:
    // PcWrite Branch PcEn IorD MemRead MemToWrite IRWrite RegDst MemToReg RegWrite AluSrcA
    // | AluSrcB | AluOp | PcSource | instr_done
    localparam logic [18:0] C_FETCH    = 19'b1_0_1_0_1_0_1_0_0_0_0_01_000_00_0;
    localparam logic [18:0] C_DECODE   = 19'b0_0_0_0_0_0_0_0_0_0_0_11_000_00_0;
    localparam logic [18:0] C_MEM_ADR  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_000_00_0;
    localparam logic [18:0] C_MEM_RD   = 19'b0_0_0_1_1_0_0_0_0_0_0_00_000_00_0;
    localparam logic [18:0] C_MEM_WB   = 19'b0_0_0_0_0_0_0_0_1_1_0_00_000_00_1;
    localparam logic [18:0] C_MEM_WR   = 19'b0_0_0_1_0_1_0_0_0_0_0_00_000_00_1;
    localparam logic [18:0] C_R_EXEC   = 19'b0_0_0_0_0_0_0_0_0_0_1_00_001_00_0;
    localparam logic [18:0] C_R_WB     = 19'b0_0_0_0_0_0_0_1_0_1_0_00_000_00_1;
    localparam logic [18:0] C_BEQ_T    = 19'b0_1_1_0_0_0_0_0_0_0_1_00_010_01_1;
    localparam logic [18:0] C_BEQ_N    = 19'b0_1_0_0_0_0_0_0_0_0_1_00_010_01_1;
    localparam logic [18:0] C_ADDI_EX  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_000_00_0;
    localparam logic [18:0] C_ANDI_EX  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_011_00_0;
    localparam logic [18:0] C_ORI_EX   = 19'b0_0_0_0_0_0_0_0_0_0_1_10_100_00_0;
    localparam logic [18:0] C_SLTI_EX  = 19'b0_0_0_0_0_0_0_0_0_0_1_10_101_00_0;
    localparam logic [18:0] C_IMM_WB   = 19'b0_0_0_0_0_0_0_0_0_1_0_00_000_00_1;
    localparam logic [18:0] C_JUMP     = 19'b1_0_1_0_0_0_0_0_0_0_0_00_000_10_1;

    typedef struct {
        logic [3:0]  st;
        logic [18:0] ctl;
        logic [31:0] cnt;
        logic        ill;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_count = 0;
    logic        exp_ill   = 1'b0;
`ifdef MC_MEM_HANDSHAKE_EN
    localparam int RD_WAIT = 2;
`else
    localparam int RD_WAIT = 0;
`endif

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Queue one expected cycle; a completing cycle bumps the model count afterwards.
    task automatic push(input logic [3:0] st, input logic [18:0] ctl, input string nm);
        exp_t r;
        r.st   = st;
        r.ctl  = ctl;
        r.cnt  = exp_count;
        r.ill  = exp_ill;
        r.name = nm;
        exp_q.push_back(r);
        if (ctl[0]) exp_count = exp_count + 1;
    endtask

    // Drive one instruction for n cycles; mem_ready low for cycles [ws, ws+wl).
    task automatic run(input logic [5:0] o, input logic z, input int n, input int ws, input int wl);
        op   = o;
        zero = z;
        for (int i = 0; i < n; i++) begin
            mem_ready = !(i >= ws && i < ws + wl);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
    endtask

    task automatic imm(input logic [5:0] o, input logic [18:0] ex, input string nm);
        push(4'd0, C_FETCH, nm);
        push(4'd1, C_DECODE, nm);
        push(4'd9, ex, nm);
        push(4'd10, C_IMM_WB, nm);
        run(o, 1'b0, 4, 0, 0);
    endtask

    // Monitor: every cycle with a queued expectation is compared at negedge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t r;
            r = exp_q.pop_front();
            check({r.name, " state"}, 64'(state), 64'(r.st));
            check({r.name, " ctl"},
                  64'({PcWrite, Branch, PcEn, IorD, MemRead, MemToWrite, IRWrite, RegDst,
                       MemToReg, RegWrite, AluSrcA, AluSrcB, AluOp, PcSource, instr_done}),
                  64'(r.ctl));
            check({r.name, " count"}, 64'(instr_count), 64'(r.cnt));
            check({r.name, " count2"}, 64'(d2_count), 64'(r.cnt[1:0]));
            check({r.name, " illegal"}, 64'(illegal_op), 64'(r.ill));
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        op        = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst state", 64'(state), 64'd0);
        check("rst strobes", 64'({PcWrite, Branch, PcEn, MemRead, MemToWrite, IRWrite, RegWrite}), 64'd0);
        check("rst done", 64'(instr_done), 64'd0);
        check("rst count", 64'(instr_count), 64'd0);
        check("rst illegal", 64'(illegal_op), 64'd0);
        reset = 1'b0;

        // R-type: 0,1,6,7
        push(4'd0, C_FETCH, "rtype"); push(4'd1, C_DECODE, "rtype");
        push(4'd6, C_R_EXEC, "rtype"); push(4'd7, C_R_WB, "rtype");
        run(6'b000000, 1'b0, 4, 0, 0);

        // lw: 0,1,2,3(+wait),4
        push(4'd0, C_FETCH, "lw"); push(4'd1, C_DECODE, "lw"); push(4'd2, C_MEM_ADR, "lw");
        for (int i = 0; i <= RD_WAIT; i++) push(4'd3, C_MEM_RD, "lw");
        push(4'd4, C_MEM_WB, "lw");
        run(6'b100011, 1'b0, 5 + RD_WAIT, 3, RD_WAIT);

        // sw: 0,1,2,5
        push(4'd0, C_FETCH, "sw"); push(4'd1, C_DECODE, "sw");
        push(4'd2, C_MEM_ADR, "sw"); push(4'd5, C_MEM_WR, "sw");
        run(6'b101011, 1'b0, 4, 0, 0);

        // beq taken / not taken
        push(4'd0, C_FETCH, "beq_t"); push(4'd1, C_DECODE, "beq_t"); push(4'd8, C_BEQ_T, "beq_t");
        run(6'b000100, 1'b1, 3, 0, 0);
        push(4'd0, C_FETCH, "beq_n"); push(4'd1, C_DECODE, "beq_n"); push(4'd8, C_BEQ_N, "beq_n");
        run(6'b000100, 1'b0, 3, 0, 0);

        // Illegal opcode: two cycles, no count, sticky flag from the next cycle on
        push(4'd0, C_FETCH, "illegal"); push(4'd1, C_DECODE, "illegal");
        exp_ill = 1'b1;
        run(6'b111111, 1'b0, 2, 0, 0);

        imm(6'b001101, C_ORI_EX, "ori");
        imm(6'b001000, C_ADDI_EX, "addi");
        imm(6'b001100, C_ANDI_EX, "andi");
        imm(6'b001010, C_SLTI_EX, "slti");

        // Reset asserted in the middle of R_WB
        op = 6'b000000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid state", 64'(state), 64'd7);
        check("mid regwrite", 64'(RegWrite), 64'd1);
        reset = 1'b1;
        #1;
        check("arst regwrite", 64'(RegWrite), 64'd0);
        check("arst state", 64'(state), 64'd0);
        check("arst count", 64'(instr_count), 64'd0);
        check("arst count2", 64'(d2_count), 64'd0);
        check("arst illegal", 64'(illegal_op), 64'd0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        exp_count = 0;
        exp_ill   = 1'b0;

        // Four jumps: narrow counter goes 0,1,2,3 and wraps to 0
        for (int k = 0; k < 4; k++) begin
            push(4'd0, C_FETCH, "jump"); push(4'd1, C_DECODE, "jump"); push(4'd11, C_JUMP, "jump");
            run(6'b000010, 1'b0, 3, 0, 0);
        end
        check("wrap count2", 64'(d2_count), 64'd0);
        check("final count", 64'(instr_count), 64'd4);

        @(negedge clk);
        check("queue drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
